// File: rtl/axis_hdr_pkg.sv
// Shared types and helpers for the AXI-Stream header insert/extract stages.
package axis_hdr_pkg;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_BODY  = 2'd1,
    ST_TAIL  = 2'd2
  } state_t;

  localparam int unsigned KEEP_MAX = 64;

  function automatic logic [6:0] keep_popcount(input logic [KEEP_MAX-1:0] keep);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      n = n + 7'(keep[i]);
    end
    return n;
  endfunction

  function automatic int unsigned byte_bits(input int unsigned nbytes);
    return nbytes << 3;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry valid/ready register slice; accepts a new word whenever it is empty
// or its current word is being taken this cycle.
module axis_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_free,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_free) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/axi_stream_extract_header.sv
// Splits the leading strip_cnt+1 bytes of each packet onto a header channel and
// MSB-realigns the payload. Optional counters: define AXIS_EXTRACT_STATS_EN.
module axi_stream_extract_header
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  input  logic [BYTE_CNT_WD-1:0]  strip_cnt,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  output logic                    valid_hdr,
  input  logic                    ready_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr
`ifdef AXIS_EXTRACT_STATS_EN
  ,
  output logic [31:0]             pkt_cnt,
  output logic [15:0]             runt_cnt
`endif
);

  localparam int unsigned W     = DATA_BYTE_WD;
  localparam int          KW    = BYTE_CNT_WD + 1;
  localparam int          PAY_W = DATA_WD + DATA_BYTE_WD + 1;
  localparam int          HDR_W = DATA_WD + DATA_BYTE_WD;

  state_t                  r_state, w_state_nxt;
  logic [KW-1:0]           r_k, w_k_nxt;
  logic [DATA_WD-1:0]      r_resid, w_resid_nxt;
  logic [DATA_BYTE_WD-1:0] r_resid_keep, w_resid_keep_nxt;

  logic [DATA_WD-1:0]      w_mask, w_din;
  logic [KW-1:0]           w_n_cnt;
  int unsigned             w_k, w_n, w_m;
  logic                    w_acc, w_pay_free, w_hdr_free;

  logic                    w_pay_vld, w_pay_last, w_hdr_vld;
  logic [DATA_WD-1:0]      w_pay_data, w_hdr_data;
  logic [DATA_BYTE_WD-1:0] w_pay_keep, w_hdr_keep;
  logic [PAY_W-1:0]        w_pay_q;
  logic [HDR_W-1:0]        w_hdr_q;

  // Null bytes are zeroed so realigned beats never carry stale data.
  for (genvar g = 0; g < DATA_BYTE_WD; g++) begin : g_mask
    assign w_mask[g*8 +: 8] = {8{keep_in[g]}};
  end

  assign w_din   = data_in & w_mask;
  assign w_n_cnt = KW'(keep_popcount(KEEP_MAX'(keep_in)));
  assign w_n     = 32'(w_n_cnt);
  assign w_k     = (r_state == ST_FIRST) ? 32'(strip_cnt) + 32'd1 : 32'(r_k);
  assign w_m     = (w_n < w_k) ? w_n : w_k;
  assign w_acc   = valid_in && ready_in;

  assign ready_in = (r_state == ST_FIRST) ? (w_hdr_free && w_pay_free) :
                    (r_state == ST_BODY)  ? w_pay_free : 1'b0;

  always_comb begin
    w_state_nxt      = r_state;
    w_k_nxt          = r_k;
    w_resid_nxt      = r_resid;
    w_resid_keep_nxt = r_resid_keep;
    w_pay_vld        = 1'b0;
    w_pay_data       = '0;
    w_pay_keep       = '0;
    w_pay_last       = 1'b0;
    w_hdr_vld        = 1'b0;
    w_hdr_data       = '0;
    w_hdr_keep       = '0;
    case (r_state)
      ST_FIRST: begin
        if (w_acc) begin
          w_k_nxt          = KW'(w_k);
          w_hdr_vld        = 1'b1;
          w_hdr_data       = w_din >> byte_bits(W - w_m);
          w_hdr_keep       = {DATA_BYTE_WD{1'b1}} >> (W - w_m);
          w_resid_nxt      = w_din << byte_bits(w_k);
          w_resid_keep_nxt = keep_in << w_k;
          if (last_in) begin
            if (w_n > w_k) begin
              w_pay_vld  = 1'b1;
              w_pay_data = w_resid_nxt;
              w_pay_keep = w_resid_keep_nxt;
              w_pay_last = 1'b1;
            end
          end else begin
            w_state_nxt = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (w_acc) begin
          w_pay_vld        = 1'b1;
          w_pay_data       = r_resid | (w_din >> byte_bits(W - w_k));
          w_pay_keep       = r_resid_keep | (keep_in >> (W - w_k));
          w_resid_nxt      = w_din << byte_bits(w_k);
          w_resid_keep_nxt = keep_in << w_k;
          if (last_in) begin
            if (w_n > w_k) begin
              w_state_nxt = ST_TAIL;
            end else begin
              w_pay_last  = 1'b1;
              w_state_nxt = ST_FIRST;
            end
          end
        end
      end
      ST_TAIL: begin
        w_pay_vld  = 1'b1;
        w_pay_data = r_resid;
        w_pay_keep = r_resid_keep;
        w_pay_last = 1'b1;
        if (w_pay_free) w_state_nxt = ST_FIRST;
      end
      default: w_state_nxt = ST_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_FIRST;
      r_k          <= '0;
      r_resid      <= '0;
      r_resid_keep <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_k          <= w_k_nxt;
      r_resid      <= w_resid_nxt;
      r_resid_keep <= w_resid_keep_nxt;
    end
  end

  axis_reg_slice #(.WIDTH(PAY_W)) u_pay_slice (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_pay_vld),
    .i_data  ({w_pay_data, w_pay_keep, w_pay_last}),
    .o_free  (w_pay_free),
    .o_valid (valid_out),
    .o_data  (w_pay_q),
    .i_ready (ready_out)
  );

  axis_reg_slice #(.WIDTH(HDR_W)) u_hdr_slice (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_hdr_vld),
    .i_data  ({w_hdr_data, w_hdr_keep}),
    .o_free  (w_hdr_free),
    .o_valid (valid_hdr),
    .o_data  (w_hdr_q),
    .i_ready (ready_hdr)
  );

  assign {data_out, keep_out, last_out} = w_pay_q;
  assign {data_hdr, keep_hdr}           = w_hdr_q;

`ifdef AXIS_EXTRACT_STATS_EN
  logic [31:0] r_pkt_cnt;
  logic [15:0] r_runt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_cnt  <= '0;
      r_runt_cnt <= '0;
    end else begin
      if (w_acc && last_in) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (w_acc && last_in && (r_state == ST_FIRST) && (w_n <= w_k))
        r_runt_cnt <= r_runt_cnt + 16'd1;
    end
  end

  assign pkt_cnt  = r_pkt_cnt;
  assign runt_cnt = r_runt_cnt;
`endif

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Bench for axi_stream_extract_header: directed scenarios plus random packets
// compared against a byte-level model of header split and payload repacking.
module tb_axi_stream_extract_header;

  localparam int DW = 32;
  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in, ready_in, last_in;
  logic [DW-1:0] data_in, data_out, data_hdr;
  logic [W-1:0]  keep_in, keep_out, keep_hdr;
  logic [CW-1:0] strip_cnt;
  logic          valid_out, ready_out, last_out;
  logic          valid_hdr, ready_hdr;
`ifdef AXIS_EXTRACT_STATS_EN
  logic [31:0]   pkt_cnt;
  logic [15:0]   runt_cnt;
`endif

  axi_stream_extract_header #(.DATA_WD(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .keep_in   (keep_in),
    .last_in   (last_in),
    .strip_cnt (strip_cnt),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out),
    .keep_out  (keep_out),
    .last_out  (last_out),
    .valid_hdr (valid_hdr),
    .ready_hdr (ready_hdr),
    .data_hdr  (data_hdr),
    .keep_hdr  (keep_hdr)
`ifdef AXIS_EXTRACT_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .runt_cnt  (runt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int stalls = 0;
  int exp_pkts = 0, exp_runts = 0, exp_tails = 0;
  logic bp_done;

  logic [7:0]    pb [0:63];
  int            plen;
  logic [DW+W:0]   got_pay[$], exp_pay[$];
  logic [DW+W-1:0] got_hdr[$], exp_hdr[$];

  // Capture every handshake; the transfer happens at the following rising edge.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_out) got_pay.push_back({data_out, keep_out, last_out});
    if (!rst && valid_hdr && ready_hdr) got_hdr.push_back({data_hdr, keep_hdr});
    if (!rst && valid_in && !ready_in) stalls <= stalls + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input int idx, input logic [31:0] w);
    for (int j = 0; j < 4; j++) pb[idx*4+j] = w[31-8*j -: 8];
  endtask

  // Reference: header = first min(k,len) bytes right-aligned; payload = the rest, packed MSB-first.
  task automatic add_expected(input int k);
    logic [DW-1:0] hd, d;
    logic [W-1:0]  hk, kp;
    int m, p, nb, lastn;
    m  = (k < plen) ? k : plen;
    hd = '0;
    hk = '0;
    for (int i = 0; i < m; i++) begin
      hd = (hd << 8) | DW'(pb[i]);
      hk = {hk[W-2:0], 1'b1};
    end
    exp_hdr.push_back({hd, hk});
    p = plen - k;
    for (int b = 0; b < p; b += W) begin
      d  = '0;
      kp = '0;
      for (int j = 0; j < W; j++) begin
        d  = d << 8;
        kp = {kp[W-2:0], 1'b0};
        if (b + j < p) begin
          d  = d | DW'(pb[k+b+j]);
          kp[0] = 1'b1;
        end
      end
      exp_pay.push_back({d, kp, (b + W >= p)});
    end
    nb    = (plen + W - 1) / W;
    lastn = plen - (nb - 1) * W;
    if (nb > 1 && lastn > k) exp_tails++;
    if (plen <= k) exp_runts++;
    exp_pkts++;
  endtask

  task automatic drive_beat(input int b, input int k);
    int nb, idx;
    nb = (plen + W - 1) / W;
    for (int j = 0; j < W; j++) begin
      idx = b * W + j;
      data_in[DW-1-8*j -: 8] = (idx < plen) ? pb[idx] : 8'($urandom);
      keep_in[W-1-j]         = (idx < plen);
    end
    last_in   = (b == nb - 1);
    strip_cnt = (b == 0) ? CW'(k - 1) : CW'($urandom);
    valid_in  = 1'b1;
  endtask

  task automatic wait_accept();
    int   t;
    logic acc;
    t   = 0;
    acc = 1'b0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      #1;
      t++;
    end
    check("accept", 64'(acc), 64'd1);
  endtask

  task automatic drive_pkt(input int k, input int gap_max);
    int nb, gap;
    nb = (plen + W - 1) / W;
    for (int b = 0; b < nb; b++) begin
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      if (gap > 0) begin
        valid_in = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      drive_beat(b, k);
      wait_accept();
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic compare_out(input string tag);
    int t, i;
    t = 0;
    while ((got_pay.size() < exp_pay.size() || got_hdr.size() < exp_hdr.size()) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_npay"}, 64'(got_pay.size()), 64'(exp_pay.size()));
    check({tag, "_nhdr"}, 64'(got_hdr.size()), 64'(exp_hdr.size()));
    i = 0;
    while (got_pay.size() > 0 && exp_pay.size() > 0) begin
      check($sformatf("%s_pay%0d", tag, i), 64'(got_pay.pop_front()), 64'(exp_pay.pop_front()));
      i++;
    end
    i = 0;
    while (got_hdr.size() > 0 && exp_hdr.size() > 0) begin
      check($sformatf("%s_hdr%0d", tag, i), 64'(got_hdr.pop_front()), 64'(exp_hdr.pop_front()));
      i++;
    end
    got_pay.delete();
    exp_pay.delete();
    got_hdr.delete();
    exp_hdr.delete();
`ifdef AXIS_EXTRACT_STATS_EN
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkts));
    check({tag, "_runt_cnt"}, 64'(runt_cnt), 64'(exp_runts));
`endif
  endtask

  task automatic rand_pkt(output int k);
    k    = int'($urandom_range(1, W));
    plen = int'($urandom_range(1, 14));
    for (int i = 0; i < plen; i++) pb[i] = 8'($urandom);
  endtask

  initial begin
    int s0, t0, k;
    rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    strip_cnt = '0; ready_out = 1'b1; ready_hdr = 1'b1; bp_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_valid_hdr", 64'(valid_hdr), 64'd0);
    check("rst_pay", 64'({data_out, keep_out, last_out}), 64'd0);
    check("rst_hdr", 64'({data_hdr, keep_hdr}), 64'd0);
    check("rst_ready_in", 64'(ready_in), 64'd1);
    @(posedge clk);
    #1;

    // Case 1 (k=2) immediately followed by case 3 (k=4): exactly one TAIL bubble
    s0 = stalls;
    load_word(0, 32'hAABBCCDD); load_word(1, 32'h11223344); load_word(2, 32'h55667788);
    plen = 12;
    add_expected(2);
    drive_pkt(2, 0);
    load_word(0, 32'h01020304); load_word(1, 32'h05060708); load_word(2, 32'h090A0B0C);
    add_expected(4);
    drive_pkt(4, 0);
    check("s13_stall_cycles", 64'(stalls - s0), 64'd1);
    compare_out("s13");

    // Case 2: k=3, partial last beat
    load_word(0, 32'hAABBCCDD); load_word(1, 32'h11223344);
    plen = 6;
    add_expected(3);
    drive_pkt(3, 0);
    compare_out("s2");

    // Case 4: runt, header visible one cycle after acceptance
    load_word(0, 32'hAABB0000);
    plen = 2;
    add_expected(3);
    drive_pkt(3, 0);
    @(negedge clk);
    check("s4_hdr_latency", 64'(valid_hdr), 64'd1);
    check("s4_hdr_value", 64'({data_hdr, keep_hdr}), 64'(exp_hdr[0]));
    check("s4_no_payload", 64'(valid_out), 64'd0);
    @(posedge clk);
    #1;
    compare_out("s4");

    // Case 5: payload stalled for 3 cycles after the first payload beat
    load_word(0, 32'hAABBCCDD); load_word(1, 32'h11223344); load_word(2, 32'h55667788);
    plen = 12;
    add_expected(2);
    fork
      drive_pkt(2, 0);
      begin
        t0 = 0;
        while (got_pay.size() < 1 && t0 < 50) begin
          @(posedge clk);
          #1;
          t0++;
        end
        ready_out = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check($sformatf("s5_hold_valid%0d", c), 64'(valid_out), 64'd1);
          check($sformatf("s5_hold_data%0d", c), 64'({data_out, keep_out, last_out}), 64'(exp_pay[1]));
          check($sformatf("s5_ready_in%0d", c), 64'(ready_in), 64'd0);
        end
        @(posedge clk);
        #1 ready_out = 1'b1;
      end
    join
    compare_out("s5");

    // Case 6: reset during BODY, then a clean case-2 packet
    load_word(0, 32'hAABBCCDD); load_word(1, 32'h11223344); load_word(2, 32'h55667788);
    plen = 12;
    drive_beat(0, 2);
    wait_accept();
    drive_beat(1, 2);
    wait_accept();
    valid_in = 1'b0;
    last_in  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("s6_valid_out", 64'(valid_out), 64'd0);
    check("s6_valid_hdr", 64'(valid_hdr), 64'd0);
    check("s6_pay_zero", 64'({data_out, keep_out, last_out}), 64'd0);
    check("s6_hdr_zero", 64'({data_hdr, keep_hdr}), 64'd0);
    got_pay.delete();
    got_hdr.delete();
    exp_pkts  = 0;
    exp_runts = 0;
    @(posedge clk);
    #1;
    load_word(0, 32'hAABBCCDD); load_word(1, 32'h11223344);
    plen = 6;
    add_expected(3);
    drive_pkt(3, 0);
    compare_out("s6");

    // Random back-to-back packets, no backpressure: one bubble per TAIL
    s0 = stalls;
    t0 = exp_tails;
    for (int n = 0; n < 20; n++) begin
      rand_pkt(k);
      add_expected(k);
      drive_pkt(k, 0);
    end
    check("r1_stall_cycles", 64'(stalls - s0), 64'(exp_tails - t0));
    compare_out("r1");

    // Random packets with idle gaps and random backpressure on both outputs
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          rand_pkt(k);
          add_expected(k);
          drive_pkt(k, 2);
        end
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1;
          ready_out = ($urandom_range(0, 3) != 0);
          ready_hdr = ($urandom_range(0, 2) != 0);
        end
        ready_out = 1'b1;
        ready_hdr = 1'b1;
      end
    join
    compare_out("r2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_stream_extract_header.md
# axi_stream_extract_header

Strips the first `strip_cnt+1` bytes of every AXI-Stream packet onto a separate header channel and realigns the remaining payload so that it is MSB-packed. It is the receive-side counterpart of the header-insert stage. It sits directly downstream of that stage, or of any link carrying its output format, and feeds payload consumers.

## Interface
- `DATA_WD`, 32, data width in bits (multiple of 8)
- `DATA_BYTE_WD`, `DATA_WD/8`, bytes per beat
- `BYTE_CNT_WD`, `$clog2(DATA_BYTE_WD)`, width of `strip_cnt`
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `valid_in` / `ready_in`  in / out  1  input stream handshake
- `data_in`  in  `DATA_WD`  byte 0 = `data_in[DATA_WD-1 -: 8]`
- `keep_in`  in  `DATA_BYTE_WD`  contiguous from MSB; all-ones except on the last beat
- `last_in`  in  1  end of packet
- `strip_cnt`  in  `BYTE_CNT_WD`  header length minus 1 (k = `strip_cnt+1`, range 1..`DATA_BYTE_WD`)
- `valid_out` / `ready_out`  out / in  1  payload handshake
- `data_out`, `keep_out`, `last_out`  out  `DATA_WD` / `DATA_BYTE_WD` / 1  realigned payload
- `valid_hdr` / `ready_hdr`  out / in  1  header handshake
- `data_hdr`, `keep_hdr`  out  `DATA_WD` / `DATA_BYTE_WD`  header, right-aligned in the low bytes (same format as the insert stage's `data_insert` / `keep_insert`)

## Operation
- FSM states: FIRST, BODY, TAIL. Reset state is FIRST.
- **FIRST**
  - `strip_cnt` is sampled into `k_reg` on the first-beat handshake.
  - Header = top min(k, n) bytes of the beat, right-aligned. n = count of ones in `keep_in`.
  - Residual register = `data_in << 8k`, `resid_keep = keep_in << k`.
  - If `last_in`:
    - n > k: emit payload = residual, with `last_out` set.
    - n ≤ k (runt): emit no payload beat.
    - Stay in FIRST.
  - Otherwise go to BODY.
- **BODY**
  - Each accepted beat emits `resid | (data_in >> 8(W-k))`, where W = `DATA_BYTE_WD`.
  - `keep_out` = `resid_keep | (keep_in >> (W-k))`.
  - Residual is reloaded from the current beat.
  - On `last_in` with n ≤ k: the emitted beat carries `last_out`; go to FIRST.
  - On `last_in` with n > k: emit a full beat; the residual holds n−k bytes; go to TAIL.
- **TAIL**
  - `ready_in` = 0.
  - Emit residual with `keep_out = resid_keep` and `last_out` = 1; go to FIRST.
- k = W:
  - The residual is always zero.
  - Payload is `data_in` unchanged; TAIL is never entered.
- Shifts of a full width or more yield zero. The byte-count sum n is `BYTE_CNT_WD+1` bits wide.
- A non-contiguous `keep_in`, or a partial `keep_in` on a non-last beat, is a protocol violation. Output for that case is unspecified.

## Timing
- Both outputs are registered slices.
  - Latency from input handshake to output valid: 1 cycle.
  - Throughput: 1 beat/cycle, plus 1 extra cycle per packet whose last beat has n > k.
- `ready_in`:
  - FIRST: (`hdr_slot_free` AND `pay_slot_free`).
  - BODY: `pay_slot_free`.
  - TAIL: 0.
  - `slot_free` = !valid OR ready.
- No combinational path from `valid_in` to `ready_in`. The path from `ready_out` / `ready_hdr` to `ready_in` is allowed.
- `valid_out`, `valid_hdr`, `data_*`, `keep_*` and `last_*` are held stable while valid && !ready.
- Reset mid-packet:
  - All outputs go to 0 on the next edge: valids, data, keep, last.
  - FSM returns to FIRST; residual and `k_reg` are cleared.
  - The partial packet is dropped.
- A header and the last payload beat of the same packet may be valid in the same cycle. They are independent and have no ordering requirement.

## Configuration
- `AXIS_EXTRACT_STATS_EN`
  - Defined: adds outputs `pkt_cnt[31:0]` and `runt_cnt[15:0]`.
    - `pkt_cnt` increments on every accepted `last_in`.
    - `runt_cnt` increments when a first beat is also last with n ≤ k.
    - Both counters wrap, reset to 0, and saturate never.
  - Undefined: these ports and counters do not exist.

## Structure
- Shared package `axis_hdr_pkg`:
  - FSM state encoding.
  - Function `keep_popcount`, which returns the count of ones in `keep`.
  - Constant byte-shift helper.
- Sub-module `axis_reg_slice`: one-entry valid/ready output register, parameterised on payload width. It is instantiated twice: payload {data, keep, last} and header {data, keep}.

## Test plan
All cases use `DATA_WD` = 32.
1. k = 2; beats AABBCCDD, 11223344, 55667788 (keep F, F, F+last)
   - Header: 0000AABB, keep 0011.
   - Payload: CCDD1122 (F), 33445566 (F), 77880000 (keep 1100, last).
2. k = 3; beats AABBCCDD (F), 11223344 (keep 1100, last)
   - Header: 00AABBCC, keep 0111.
   - Payload: DD112200, keep 1110, last.
3. k = 4; three full beats
   - Header equals beat 0.
   - Payload equals beats 1 and 2 unchanged, last on beat 2; no TAIL cycle.
4. k = 3; single beat AABB0000 (keep 1100, last)
   - Header: 0000AABB, keep 0011.
   - No payload beat; `runt_cnt` = 1 with `AXIS_EXTRACT_STATS_EN`.
5. Case 1 with `ready_out` low for 3 cycles after the first payload beat
   - Output held stable and `ready_in` = 0 while stalled.
   - Identical byte sequence, no loss or duplication.
6. Assert `rst` for 1 cycle during BODY of case 1
   - All outputs 0 next cycle.
   - A following case-2 packet is extracted exactly as in scenario 2.
